// File: rtl/ahfp_cordic_range_fold.sv
// Range-fold wrapper around the CORDIC cosine pipeline: folds a Q2.29 angle into
// [-pi/2, pi/2] and sign-corrects the returned cosine. Define AHFP_CORDIC_SIN_EN to add the sine path.
module ahfp_cordic_range_fold #(
    parameter int CORDIC_LAT = 10,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_theta,
    output logic [WIDTH-1:0] theta_out,
    output logic [WIDTH-1:0] x_start,
    output logic [WIDTH-1:0] y_start,
    input  logic [WIDTH-1:0] x_cos_in,
    output logic             res_valid,
    output logic [WIDTH-1:0] cos_out,
    output logic             res_neg
`ifdef AHFP_CORDIC_SIN_EN
    ,
    input  logic [WIDTH-1:0] y_sin_in,
    output logic [WIDTH-1:0] sin_out
`endif
);

    localparam logic signed [WIDTH-1:0] C_PI          = WIDTH'(32'h6487ED51);
    localparam logic signed [WIDTH-1:0] C_HALF_PI     = WIDTH'(32'h3243F6A8);
    localparam logic signed [WIDTH-1:0] C_NEG_HALF_PI = WIDTH'(32'hCDBC0958);

    typedef enum logic {S_IDLE, S_FOLD} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_accept;
    logic signed [WIDTH-1:0] r_theta_p0;
    logic signed [WIDTH-1:0] w_fold_theta;
    logic                    w_fold_neg;
    logic        [WIDTH-1:0] r_theta_p1;
    logic                    r_vld_p1;
    logic                    r_neg_p1;
    logic   [CORDIC_LAT-1:0] r_vld_dl;
    logic   [CORDIC_LAT-1:0] r_neg_dl;
    logic                    r_vld_p2;
    logic        [WIDTH-1:0] r_cos_p2;
    logic                    r_neg_p2;

    function automatic logic [WIDTH-1:0] f_cond_neg(input logic signed [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    assign x_start   = WIDTH'(32'h20000000);
    assign y_start   = '0;
    assign theta_out = r_theta_p1;
    assign res_valid = r_vld_p2;
    assign cos_out   = r_cos_p2;
    assign res_neg   = r_neg_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FOLD;
                end
            end
            S_FOLD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // p0: captured request angle
    always_ff @(posedge clk) begin
        if (w_accept) r_theta_p0 <= in_theta;
    end

    // One fold suffices because the input range is [-4,4) and pi > 3.
    always_comb begin
        w_fold_theta = r_theta_p0;
        w_fold_neg   = 1'b0;
        if (r_theta_p0 > C_HALF_PI) begin
            w_fold_theta = r_theta_p0 - C_PI;
            w_fold_neg   = 1'b1;
        end else if (r_theta_p0 < C_NEG_HALF_PI) begin
            w_fold_theta = r_theta_p0 + C_PI;
            w_fold_neg   = 1'b1;
        end
    end

    // p1: folded angle to the CORDIC, flag enters the delay line alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_theta_p1 <= '0;
            r_vld_p1   <= 1'b0;
            r_neg_p1   <= 1'b0;
            r_vld_dl   <= '0;
            r_neg_dl   <= '0;
        end else begin
            r_vld_p1 <= (r_state == S_FOLD);
            r_neg_p1 <= w_fold_neg;
            if (r_state == S_FOLD) r_theta_p1 <= w_fold_theta;
            r_vld_dl <= {r_vld_dl[CORDIC_LAT-2:0], r_vld_p1};
            r_neg_dl <= {r_neg_dl[CORDIC_LAT-2:0], r_neg_p1};
        end
    end

    // p2: tail of the delay line lines up with the CORDIC result for that angle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2 <= 1'b0;
            r_cos_p2 <= '0;
            r_neg_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_dl[CORDIC_LAT-1];
            if (r_vld_dl[CORDIC_LAT-1]) begin
                r_cos_p2 <= f_cond_neg(x_cos_in, r_neg_dl[CORDIC_LAT-1]);
                r_neg_p2 <= r_neg_dl[CORDIC_LAT-1];
            end
        end
    end

`ifdef AHFP_CORDIC_SIN_EN
    logic [WIDTH-1:0] r_sin_p2;

    assign sin_out = r_sin_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_sin_p2 <= '0;
        else if (r_vld_dl[CORDIC_LAT-1]) r_sin_p2 <= f_cond_neg(y_sin_in, r_neg_dl[CORDIC_LAT-1]);
    end
`endif

endmodule

// File: tb/tb_ahfp_cordic_range_fold.sv
// Bench for ahfp_cordic_range_fold: CORDIC stand-in plus cycle scoreboard, directed vectors and random requests.
module tb_ahfp_cordic_range_fold;

    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_theta = '0;
    logic [31:0] theta_out, x_start, y_start;
    logic [31:0] x_cos_in = '0;
    logic        res_valid;
    logic [31:0] cos_out;
    logic        res_neg;

    ahfp_cordic_range_fold #(.CORDIC_LAT(LAT), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_theta(in_theta), .theta_out(theta_out), .x_start(x_start), .y_start(y_start),
        .x_cos_in(x_cos_in), .res_valid(res_valid), .cos_out(cos_out), .res_neg(res_neg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in CORDIC result as a function of the angle it was given.
    function automatic logic [31:0] cmodel(input logic [31:0] t);
        return (t == 32'h0) ? 32'h20000000 : (t ^ 32'h5A5A5A5A);
    endfunction

    // {neg, folded angle} from the fold rules on the signed angle value.
    function automatic logic [32:0] ref_fold(input logic [31:0] t);
        longint a;
        a = longint'($signed(t));
        if (a > 64'sh3243F6A8)           return {1'b1, 32'(a - 64'sh6487ED51)};
        if (a < -64'sh3243F6A8)          return {1'b1, 32'(a + 64'sh6487ED51)};
        return {1'b0, t};
    endfunction

    typedef struct {
        int          due;
        logic [31:0] val;
        logic        neg;
    } ev_t;

    ev_t         th_q[$];
    ev_t         rs_q[$];
    logic [31:0] hist [64] = '{default: '0};
    int          ncyc = 0;
    logic        acc_prev = 1'b0;
    logic [31:0] e_theta = '0, e_cos = '0, gv;
    logic        e_neg = 1'b0, e_rv, e_rdy;
    logic [32:0] f;

    // Cycle scoreboard plus CORDIC stand-in delaying the angle by LAT cycles.
    always @(negedge clk) begin
        hist[ncyc % 64] = theta_out;
        x_cos_in = cmodel(hist[(ncyc - LAT + 640) % 64]);
        if (!rst_n) begin
            chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
            chk("rst_theta_out", theta_out, 32'h0);
            chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
            chk("rst_cos_out", cos_out, 32'h0);
            chk("rst_res_neg", {31'b0, res_neg}, 32'd0);
            th_q.delete();
            rs_q.delete();
            acc_prev = 1'b0;
            e_theta = '0;
            e_cos = '0;
            e_neg = 1'b0;
        end else begin
            e_rdy = !acc_prev;
            if (th_q.size() > 0 && th_q[0].due == ncyc) begin
                e_theta = th_q[0].val;
                void'(th_q.pop_front());
            end
            e_rv = 1'b0;
            if (rs_q.size() > 0 && rs_q[0].due == ncyc) begin
                e_rv = 1'b1;
                e_cos = rs_q[0].val;
                e_neg = rs_q[0].neg;
                void'(rs_q.pop_front());
            end
            chk("in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
            chk("theta_out", theta_out, e_theta);
            chk("res_valid", {31'b0, res_valid}, {31'b0, e_rv});
            chk("cos_out", cos_out, e_cos);
            chk("res_neg", {31'b0, res_neg}, {31'b0, e_neg});
            acc_prev = in_valid && e_rdy;
            if (acc_prev) begin
                f = ref_fold(in_theta);
                gv = cmodel(f[31:0]);
                th_q.push_back('{ncyc + 2, f[31:0], f[32]});
                rs_q.push_back('{ncyc + LAT + 3, f[32] ? (32'h0 - gv) : gv, f[32]});
            end
        end
        ncyc++;
    end

    typedef struct {
        logic [31:0] th;
        logic [31:0] tout;
        logic        neg;
        logic        ck;
        logic [31:0] cos;
    } vec_t;

    vec_t tab[8];

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [31:0] th, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        in_theta = th;
        in_valid = 1'b1;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: theta %h never accepted", th);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        bit ok;
        send(v.th, ok);
        if (ok) begin
            repeat (2) @(negedge clk);
            chk("vec_theta_out", theta_out, v.tout);
            repeat (LAT) @(negedge clk);
            chk("vec_no_early_valid", {31'b0, res_valid}, 32'd0);
            @(negedge clk);
            chk("vec_res_valid", {31'b0, res_valid}, 32'd1);
            chk("vec_res_neg", {31'b0, res_neg}, {31'b0, v.neg});
            if (v.ck) chk("vec_cos_out", cos_out, v.cos);
            @(negedge clk);
            chk("vec_pulse_end", {31'b0, res_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] burst[4];
        logic        bneg[4];
        int          pcyc[$];
        logic        pneg[$];
        bit          ok;
        int          n;
        logic [31:0] r;

        tab[0] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h20000000};
        tab[1] = '{32'h6487ED51, 32'h00000000, 1'b1, 1'b1, 32'hE0000000};
        tab[2] = '{32'h3243F6A8, 32'h3243F6A8, 1'b0, 1'b1, 32'h6819ACF2};
        tab[3] = '{32'h3243F6A9, 32'hCDBC0958, 1'b1, 1'b0, 32'h0};
        tab[4] = '{32'hCDBC0957, 32'h3243F6A8, 1'b1, 1'b0, 32'h0};
        tab[5] = '{32'hCDBC0958, 32'hCDBC0958, 1'b0, 1'b0, 32'h0};
        tab[6] = '{32'h7FFFFFFF, 32'h1B7812AE, 1'b1, 1'b0, 32'h0};
        tab[7] = '{32'h80000000, 32'hE487ED51, 1'b1, 1'b0, 32'h0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("x_start", x_start, 32'h20000000);
        chk("y_start", y_start, 32'h00000000);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) apply_vec(tab[i]);

        // Back-to-back requests with in_valid held high.
        burst = '{32'h10000000, 32'h50000000, 32'hB0000000, 32'hF0000000};
        bneg  = '{1'b0, 1'b1, 1'b1, 1'b0};
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_theta = burst[i];
            ok = 1'b0;
            n = 0;
            while (!ok && n < 20) begin
                @(negedge clk);
                n++;
                if (in_ready) ok = 1'b1;
            end
            if (!ok) begin
                errors++;
                checks++;
                $display("FAIL burst_timeout: request %0d not accepted", i);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < LAT + 14; c++) begin
            @(negedge clk);
            if (res_valid) begin
                pcyc.push_back(c);
                pneg.push_back(res_neg);
            end
        end
        chk("burst_pulses", pcyc.size(), 32'd4);
        if (pcyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("burst_neg", {31'b0, pneg[i]}, {31'b0, bneg[i]});
                if (i > 0) chk("burst_spacing", pcyc[i] - pcyc[i-1], 32'd2);
            end
        end
        @(posedge clk);
        #1;

        // Reset three cycles after acceptance.
        send(32'h40000000, ok);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_theta_out", theta_out, 32'h0);
        chk("midrst_cos_out", cos_out, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < LAT + 6; c++) begin
            @(negedge clk);
            if (res_valid) n++;
        end
        chk("midrst_no_result", n, 32'd0);
        @(posedge clk);
        #1;
        apply_vec('{32'hC0000000, 32'h2487ED51, 1'b1, 1'b0, 32'h0});

        // Random angles with random idle gaps; near-boundary values mixed in.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            case ($urandom_range(0, 3))
                0:       r = 32'h3243F6A8 + 32'($urandom_range(0, 4)) - 32'd2;
                1:       r = 32'hCDBC0958 + 32'($urandom_range(0, 4)) - 32'd2;
                default: r = $urandom;
            endcase
            send(r, ok);
        end
        repeat (LAT + 6) @(posedge clk);
        #1;
        chk("drain_pending", rs_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
